// File: rtl/display_pkg.sv
// Shared display definitions: scanner states, default timing and anode polarity.
package display_pkg;

    typedef enum logic {
        StBlank,
        StShow
    } scan_state_e;

    localparam int unsigned CLK_HZ               = 100_000_000;
    localparam int unsigned DWELL_CYCLES_DEFAULT = 100_000;
    localparam int unsigned BLANK_CYCLES_DEFAULT = 1_000;

    // Anodes are active-low, so a 1 turns a digit off.
    localparam logic ANODE_OFF = 1'b1;

endpackage

// File: rtl/lz_mask.sv
// Leading-zero suppression: flags every digit above digit 0 whose nibble and all
// higher nibbles are zero.
module lz_mask #(
    parameter int unsigned N_DIGITS = 8
) (
    input  logic [4*N_DIGITS-1:0] active_i,
    input  logic                  lz_blank_i,
    output logic [N_DIGITS-1:0]   suppress_o
);

    logic zero_run;

    always_comb begin
        suppress_o = '0;
        zero_run   = lz_blank_i;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            zero_run      = zero_run & (active_i[4*i +: 4] == 4'd0);
            suppress_o[i] = zero_run;
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed scanner for an active-low multi-digit seven-segment display with
// double-buffered BCD contents and a blank gap before every digit.
module seven_seg_scanner
    import display_pkg::*;
#(
    parameter int unsigned N_DIGITS     = 8,
    parameter int unsigned DWELL_CYCLES = DWELL_CYCLES_DEFAULT,
    parameter int unsigned BLANK_CYCLES = BLANK_CYCLES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic                  lz_blank,
    output logic [3:0]            bcd,
    output logic [N_DIGITS-1:0]   anode,
    output logic                  frame_done
);

    localparam int unsigned IdxW      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned MaxCycles = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES
                                                                      : BLANK_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    scan_state_e           state_q, state_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [4*N_DIGITS-1:0] active_q, active_d;
    logic [4*N_DIGITS-1:0] shadow_q, shadow_d;
    logic                  pending_q, pending_d;
    logic [3:0]            bcd_q, bcd_d;
    logic [N_DIGITS-1:0]   anode_q, anode_d;
    logic                  frame_done_q, frame_done_d;

    logic                  boundary;
    logic                  visible;
    logic [N_DIGITS-1:0]   suppress_d;
    logic [3:0]            nib_d [N_DIGITS];

    // Outputs are registered from next-state values so they line up with the state.
    lz_mask #(
        .N_DIGITS (N_DIGITS)
    ) u_lz_mask (
        .active_i   (active_d),
        .lz_blank_i (lz_blank),
        .suppress_o (suppress_d)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q + CntW'(1);
        boundary = 1'b0;
        unique case (state_q)
            StBlank: begin
                if (cnt_q == CntW'(BLANK_CYCLES - 1)) begin
                    state_d = StShow;
                    cnt_d   = '0;
                end
            end
            StShow: begin
                if (cnt_q == CntW'(DWELL_CYCLES - 1)) begin
                    state_d = StBlank;
                    cnt_d   = '0;
                    if (idx_q == IdxW'(N_DIGITS - 1)) begin
                        idx_d    = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            default: begin
                state_d = StBlank;
                cnt_d   = '0;
            end
        endcase
    end

    // A load coinciding with the frame boundary bypasses the shadow register.
    always_comb begin
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (boundary && load) begin
            active_d  = digits_in;
            shadow_d  = digits_in;
            pending_d = 1'b0;
        end else if (load) begin
            shadow_d  = digits_in;
            pending_d = 1'b1;
        end else if (boundary && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < N_DIGITS; i++) begin
            nib_d[i] = active_d[4*i +: 4];
        end
        bcd_d        = nib_d[idx_d];
        visible      = digit_en[idx_d] & ~suppress_d[idx_d];
        anode_d      = {N_DIGITS{ANODE_OFF}};
        if ((state_d == StShow) && visible) begin
            anode_d[idx_d] = ~ANODE_OFF;
        end
        frame_done_d = boundary;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StBlank;
            idx_q        <= '0;
            cnt_q        <= '0;
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            bcd_q        <= '0;
            anode_q      <= {N_DIGITS{ANODE_OFF}};
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            bcd_q        <= bcd_d;
            anode_q      <= anode_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bcd        = bcd_q;
    assign anode      = anode_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: directed and random steps against a
// time-slot reference model of the display scan.
module tb_seven_seg_scanner;

    localparam int unsigned N     = 4;
    localparam int unsigned DWELL = 4;
    localparam int unsigned BLANK = 2;
    localparam int unsigned SLOT  = BLANK + DWELL;
    localparam int unsigned FRAME = N * SLOT;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load = 1'b0;
    logic [15:0]   digits_in = '0;
    logic [3:0]    digit_en = '0;
    logic          lz_blank = 1'b0;
    logic [3:0]    bcd;
    logic [3:0]    anode;
    logic          frame_done;

    int            errors = 0;
    int            checks = 0;

    // Reference model state
    int            t;
    logic [15:0]   m_active;
    logic [15:0]   m_shadow;
    logic          m_pending;

    seven_seg_scanner #(
        .N_DIGITS     (N),
        .DWELL_CYCLES (DWELL),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .digits_in  (digits_in),
        .digit_en   (digit_en),
        .lz_blank   (lz_blank),
        .bcd        (bcd),
        .anode      (anode),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        t         = 0;
        m_active  = '0;
        m_shadow  = '0;
        m_pending = 1'b0;
    endtask

    // Expected outputs in cycle t, given the enables sampled at the edge into it.
    task automatic check_outputs(input logic [3:0] en, input logic lz);
        int          pos;
        int          slot;
        logic        show;
        logic        supp;
        logic [3:0]  exp_anode;
        logic [3:0]  exp_bcd;
        logic        exp_fd;
        logic [15:0] upper;
        pos       = t % FRAME;
        slot      = pos / SLOT;
        show      = (pos % SLOT) >= BLANK;
        upper     = m_active >> (4 * slot);
        supp      = lz && (slot != 0) && (upper == 16'h0);
        exp_bcd   = upper[3:0];
        exp_anode = 4'hF;
        if (show && en[slot] && !supp) exp_anode[slot] = 1'b0;
        exp_fd    = (t > 0) && (pos == 0);
        checks++;
        assert (anode === exp_anode) else begin
            errors++;
            $error("FAIL anode t=%0d got %h exp %h", t, anode, exp_anode);
        end
        checks++;
        assert (bcd === exp_bcd) else begin
            errors++;
            $error("FAIL bcd t=%0d got %h exp %h", t, bcd, exp_bcd);
        end
        checks++;
        assert (frame_done === exp_fd) else begin
            errors++;
            $error("FAIL frame_done t=%0d got %b exp %b", t, frame_done, exp_fd);
        end
    endtask

    task automatic step(input logic ld, input logic [15:0] din, input logic [3:0] en,
                        input logic lz);
        logic boundary;
        load      = ld;
        digits_in = din;
        digit_en  = en;
        lz_blank  = lz;
        @(posedge clk);
        t++;
        boundary = (t % FRAME) == 0;
        if (boundary) begin
            if (ld) begin
                m_active = din;
                m_shadow = din;
            end else if (m_pending) begin
                m_active = m_shadow;
            end
            m_pending = 1'b0;
        end else if (ld) begin
            m_shadow  = din;
            m_pending = 1'b1;
        end
        #1;
        load = 1'b0;
        check_outputs(en, lz);
    endtask

    task automatic idle_to(input int pos, input logic [3:0] en, input logic lz);
        for (int k = 0; k < FRAME && (t % FRAME) != pos; k++) step(1'b0, 16'h0, en, lz);
    endtask

    task automatic idle(input int n, input logic [3:0] en, input logic lz);
        for (int k = 0; k < n; k++) step(1'b0, 16'h0, en, lz);
    endtask

    initial begin
        logic [15:0] masks [5];
        masks = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
        model_reset();

        // Reset held: outputs at reset values
        repeat (3) @(posedge clk);
        #1;
        check_outputs(4'hF, 1'b0);
        reset = 1'b0;
        model_reset();
        check_outputs(4'hF, 1'b0);

        // First frame of zeros, frame_done at cycle 24
        idle(FRAME + 6, 4'hF, 1'b0);

        // Mid-frame load becomes visible only at the boundary
        idle_to(10, 4'hF, 1'b0);
        step(1'b1, 16'h1234, 4'hF, 1'b0);
        idle(2 * FRAME, 4'hF, 1'b0);

        // Leading-zero suppression on and off
        step(1'b1, 16'h0050, 4'hF, 1'b1);
        idle(2 * FRAME, 4'hF, 1'b1);
        idle(FRAME, 4'hF, 1'b0);

        step(1'b1, 16'h0000, 4'hF, 1'b1);
        idle(2 * FRAME, 4'hF, 1'b1);

        // Load exactly on the boundary edge
        idle_to(FRAME - 1, 4'hF, 1'b0);
        step(1'b1, 16'hABCD, 4'hF, 1'b0);
        idle(FRAME, 4'hF, 1'b0);

        // Multiple loads in one frame: last one wins
        idle_to(3, 4'hF, 1'b0);
        step(1'b1, 16'h1111, 4'hF, 1'b0);
        step(1'b1, 16'h2222, 4'hF, 1'b0);
        idle(5, 4'hF, 1'b0);
        step(1'b1, 16'h0706, 4'hF, 1'b1);
        idle(2 * FRAME, 4'hF, 1'b1);

        // Random loads, enables and suppression
        for (int k = 0; k < 300; k++) begin
            logic        ld;
            logic [15:0] din;
            ld  = ($urandom_range(0, 9) == 0);
            din = 16'($urandom) & masks[$urandom_range(0, 4)];
            step(ld, din, 4'($urandom), 1'($urandom_range(0, 3) != 0));
        end

        // Reset in SHOW of idx 2 discards a pending load
        idle_to(FRAME - 1, 4'hF, 1'b0);
        idle(1, 4'hF, 1'b0);
        step(1'b1, 16'h9999, 4'hF, 1'b0);
        idle_to(2 * SLOT + BLANK + 1, 4'hF, 1'b0);
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs(4'hF, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_outputs(4'hF, 1'b0);
        idle(FRAME + SLOT, 4'hF, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
